// File: rtl/trace_pkg.sv
// Shared trace definitions: record layout, capture states and the record pack helper.
// Also consumed by the trace logger, so field offsets must stay stable.
package trace_pkg;

    localparam int REC_W          = 106;
    localparam int RD_VALUE_LSB   = 0;
    localparam int IMM_LSB        = 32;
    localparam int RS1_LSB        = 64;
    localparam int RD_LSB         = 69;
    localparam int INSTR_LSB      = 74;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic [REC_W-1:0] pack_rec(
        input logic [31:0] instr,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [31:0] imm,
        input logic [31:0] rd_value
    );
        return {instr, rd, rs1, imm, rd_value};
    endfunction

endpackage

// File: rtl/trace_capture_ctrl_if.sv
// Writeback record input and drain output of the trace capture controller.
interface trace_capture_ctrl_if;
    import trace_pkg::*;

    logic              in_valid;
    logic [31:0]       in_instr;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [31:0]       in_imm;
    logic [31:0]       in_rd_value;
    logic              out_valid;
    logic              out_ready;
    logic [REC_W-1:0]  out_rec;

    modport master (
        output in_valid, in_instr, in_rd, in_rs1, in_imm, in_rd_value, out_ready,
        input  out_valid, out_rec
    );

    modport slave (
        input  in_valid, in_instr, in_rd, in_rs1, in_imm, in_rd_value, out_ready,
        output out_valid, out_rec
    );

endinterface

// File: rtl/trace_ring_buf.sv
// Circular record store: a write when full overwrites the oldest entry, and
// the read port always presents the entry at rd_ptr.
module trace_ring_buf
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [REC_W-1:0]  wr_data,
    input  logic              rd_en,
    output logic [REC_W-1:0]  rd_data,
    output logic [PTR_W:0]    count,
    output logic              full
);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [REC_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    assign full    = (count_r == CNT_FULL);
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; a full write drags rd_ptr along.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (clr) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (wr_en) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (full) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                count_r <= count_r + CNT_ONE;
            end
        end else if (rd_en && (count_r != '0)) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
            count_r  <= count_r - CNT_ONE;
        end
    end

    // Record storage; contents are only observed through the gated drain port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trigger-driven capture of retired-instruction records with pre/post history,
// followed by an oldest-first drain to the trace sink.
module trace_capture_ctrl
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    trace_capture_ctrl_if.slave  bus,
    input  logic                 arm,
    input  logic                 abort,
    input  logic [31:0]          trig_instr,
    input  logic [31:0]          trig_mask,
    input  logic [PTR_W-1:0]     post_count,
    output logic [1:0]           state_o,
    output logic                 triggered,
    output logic                 overflow
);

    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

    state_e            state_r, state_nx;
    logic [PTR_W-1:0]  post_rem_r, post_rem_nx;
    logic              triggered_r, triggered_nx;
    logic              overflow_r, overflow_nx;
    logic              clr_s, wr_en_s, rd_en_s;
    logic              full_s, qual_s, match_s;
    logic [PTR_W:0]    count_s;
    logic [REC_W-1:0]  wr_data_s, rd_data_s;
    logic              out_valid_s;

    // Bubbles (instr 0) are neither stored nor allowed to trigger.
    assign qual_s    = bus.in_valid && (bus.in_instr != 32'd0);
    assign match_s   = qual_s && (((bus.in_instr ^ trig_instr) & trig_mask) == 32'd0);
    assign wr_data_s = pack_rec(bus.in_instr, bus.in_rd, bus.in_rs1, bus.in_imm, bus.in_rd_value);

    trace_ring_buf #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr_s),
        .wr_en   (wr_en_s),
        .wr_data (wr_data_s),
        .rd_en   (rd_en_s),
        .rd_data (rd_data_s),
        .count   (count_s),
        .full    (full_s)
    );

    assign out_valid_s   = (state_r == ST_DONE) && (count_s != '0);
    assign bus.out_valid = out_valid_s;
    assign bus.out_rec   = out_valid_s ? rd_data_s : '0;
    assign state_o       = state_r;
    assign triggered     = triggered_r;
    assign overflow      = overflow_r;

    // State, post-trigger counter and sticky capture flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            post_rem_r  <= '0;
            triggered_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            state_r     <= state_nx;
            post_rem_r  <= post_rem_nx;
            triggered_r <= triggered_nx;
            overflow_r  <= overflow_nx;
        end
    end

    // Next-state and buffer control; abort outranks arm and any capture.
    always_comb begin
        state_nx     = state_r;
        post_rem_nx  = post_rem_r;
        triggered_nx = triggered_r;
        overflow_nx  = overflow_r;
        clr_s        = 1'b0;
        wr_en_s      = 1'b0;
        rd_en_s      = 1'b0;
        if (abort) begin
            state_nx = ST_IDLE;
            clr_s    = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) begin
                        clr_s        = 1'b1;
                        triggered_nx = 1'b0;
                        overflow_nx  = 1'b0;
                        post_rem_nx  = post_count;
                        state_nx     = ST_ARMED;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (qual_s) begin
                        wr_en_s     = 1'b1;
                        overflow_nx = overflow_r | full_s;
                        if (match_s) begin
                            triggered_nx = 1'b1;
                            state_nx     = (post_rem_r == '0) ? ST_DONE : ST_POST;
                        end else begin
                            state_nx = ST_ARMED;
                        end
                    end else begin
                        state_nx = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (qual_s) begin
                        wr_en_s     = 1'b1;
                        overflow_nx = overflow_r | full_s;
                        post_rem_nx = post_rem_r - PTR_ONE;
                        state_nx    = (post_rem_r == PTR_ONE) ? ST_DONE : ST_POST;
                    end else begin
                        state_nx = ST_POST;
                    end
                end
                ST_DONE: begin
                    if (count_s == '0) begin
                        state_nx = ST_IDLE;
                    end else if (bus.out_ready) begin
                        rd_en_s  = 1'b1;
                        state_nx = (count_s == CNT_ONE) ? ST_IDLE : ST_DONE;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    clr_s    = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// Scoreboard bench for trace_capture_ctrl with DEPTH=8.
module tb_trace_capture_ctrl;

    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic [31:0]       trig_instr = 32'd0;
    logic [31:0]       trig_mask = 32'd0;
    logic [PTR_W-1:0]  post_count = 3'd0;
    logic [1:0]        state_o;
    logic              triggered;
    logic              overflow;

    trace_capture_ctrl_if tif ();

    trace_capture_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (tif.slave),
        .arm        (arm),
        .abort      (abort),
        .trig_instr (trig_instr),
        .trig_mask  (trig_mask),
        .post_count (post_count),
        .state_o    (state_o),
        .triggered  (triggered),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;
    logic [105:0] exp_q [$];
    int m_state = 0;
    int m_post  = 0;

    task automatic step_rec(input logic [31:0] instr, input logic v);
        logic [105:0] r;
        @(negedge clk);
        tif.in_valid    = v;
        tif.in_instr    = instr;
        tif.in_rd       = instr[11:7];
        tif.in_rs1      = instr[19:15];
        tif.in_imm      = {{20{instr[31]}}, instr[31:20]} ^ 32'h0000_0F00;
        tif.in_rd_value = instr * 32'd3 + 32'h1000_0000;
        r = {tif.in_instr, tif.in_rd, tif.in_rs1, tif.in_imm, tif.in_rd_value};
        if ((m_state == 1 || m_state == 2) && v && instr != 32'd0) begin
            exp_q.push_back(r);
            if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            if (m_state == 1) begin
                if (((instr ^ trig_instr) & trig_mask) == 32'd0)
                    m_state = (m_post == 0) ? 3 : 2;
            end else begin
                m_post = m_post - 1;
                if (m_post == 0) m_state = 3;
            end
        end
        @(posedge clk); #1;
        tif.in_valid = 1'b0;
    endtask

    task automatic do_arm(input logic [PTR_W-1:0] pc);
        @(negedge clk);
        post_count = pc;
        arm = 1'b1;
        if (m_state == 0) begin
            exp_q.delete();
            m_post  = int'(pc);
            m_state = 1;
        end
        @(posedge clk); #1;
        arm = 1'b0;
    endtask

    task automatic drain(input int exp_n, input bit bp, input string nm);
        int got = 0;
        int cyc = 0;
        bit rdy;
        logic [105:0] e;
        while (got < exp_n && cyc < 200) begin
            @(negedge clk);
            rdy = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            tif.out_ready = rdy;
            cyc++;
            if (tif.out_valid) begin
                e = (exp_q.size() > 0) ? exp_q[0] : '0;
                n_chk++;
                if (tif.out_rec !== e) $display("FAIL %s rec[%0d]: got %h expected %h", nm, got, tif.out_rec, e);
                else n_pass++;
                if (rdy) begin
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    got++;
                end
            end
        end
        @(posedge clk); #1;
        tif.out_ready = 1'b0;
        m_state = 0;
        n_chk++;
        if (got !== exp_n) $display("FAIL %s count: got %0d expected %0d", nm, got, exp_n);
        else n_pass++;
        n_chk++;
        if (state_o !== 2'd0 || tif.out_valid !== 1'b0)
            $display("FAIL %s end: state %0d valid %b expected state 0 valid 0", nm, state_o, tif.out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        n_chk++;
        if (state_o !== 2'd0 || tif.out_valid !== 1'b0 || tif.out_rec !== 106'd0 || triggered !== 1'b0 || overflow !== 1'b0)
            $display("FAIL reset: state %0d valid %b rec %h trig %b ovf %b expected all 0", state_o, tif.out_valid, tif.out_rec, triggered, overflow);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [31:0] ins [4] = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213};
        trig_mask = 32'd0;
        do_arm(3'd3);
        n_chk++;
        if (state_o !== 2'd1) $display("FAIL basic armed: state %0d expected 1", state_o); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            step_rec(ins[i], 1'b1);
            if (i == 0) begin
                n_chk++;
                if (state_o !== 2'd2) $display("FAIL basic post: state %0d expected 2", state_o); else n_pass++;
            end
        end
        n_chk++;
        if (state_o !== 2'd3 || triggered !== 1'b1 || overflow !== 1'b0)
            $display("FAIL basic done: state %0d trig %b ovf %b expected 3 1 0", state_o, triggered, overflow);
        else n_pass++;
        drain(4, 1'b0, "basic");
    endtask

    task automatic test_overflow();
        trig_instr = 32'h00A00513;
        trig_mask  = 32'hFFFF_FFFF;
        do_arm(3'd2);
        for (int i = 0; i < 12; i++)
            step_rec((i == 9) ? 32'h00A00513 : (32'h0000_0013 | ((i + 1) << 15)), 1'b1);
        n_chk++;
        if (state_o !== 2'd3 || triggered !== 1'b1 || overflow !== 1'b1)
            $display("FAIL overflow done: state %0d trig %b ovf %b expected 3 1 1", state_o, triggered, overflow);
        else n_pass++;
        drain(8, 1'b0, "overflow");
    endtask

    task automatic test_bubbles();
        trig_instr = 32'd0;
        trig_mask  = 32'hFFFF_FFFF;
        do_arm(3'd1);
        step_rec(32'd0, 1'b1);
        step_rec(32'h00100093, 1'b1);
        step_rec(32'd0, 1'b1);
        step_rec(32'h00700393, 1'b0);
        step_rec(32'h00200113, 1'b1);
        step_rec(32'd0, 1'b1);
        n_chk++;
        if (state_o !== 2'd1 || triggered !== 1'b0)
            $display("FAIL bubble trigger: state %0d trig %b expected 1 0", state_o, triggered);
        else n_pass++;
        trig_instr = 32'h00300193;
        step_rec(32'h00300193, 1'b1);
        step_rec(32'd0, 1'b1);
        n_chk++;
        if (state_o !== 2'd2) $display("FAIL bubble post: state %0d expected 2", state_o); else n_pass++;
        step_rec(32'h00400213, 1'b1);
        n_chk++;
        if (state_o !== 2'd3) $display("FAIL bubble done: state %0d expected 3", state_o); else n_pass++;
        drain(4, 1'b0, "bubble");
    endtask

    task automatic test_backpressure();
        trig_mask = 32'd0;
        do_arm(3'd4);
        for (int i = 0; i < 5; i++) step_rec(32'h0050_0293 + (i << 20), 1'b1);
        drain(5, 1'b1, "backpressure");
    endtask

    task automatic test_abort();
        trig_mask = 32'd0;
        do_arm(3'd3);
        step_rec(32'h00100093, 1'b1);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        m_state = 0;
        exp_q.delete();
        n_chk++;
        if (state_o !== 2'd0 || tif.out_valid !== 1'b0)
            $display("FAIL abort post: state %0d valid %b expected 0 0", state_o, tif.out_valid);
        else n_pass++;
        @(negedge clk);
        abort = 1'b1;
        arm = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        arm = 1'b0;
        n_chk++;
        if (state_o !== 2'd0) $display("FAIL abort arm: state %0d expected 0", state_o); else n_pass++;
        do_arm(3'd0);
        step_rec(32'h00900493, 1'b1);
        n_chk++;
        if (state_o !== 2'd3 || triggered !== 1'b1 || overflow !== 1'b0)
            $display("FAIL abort rearm: state %0d trig %b ovf %b expected 3 1 0", state_o, triggered, overflow);
        else n_pass++;
        drain(1, 1'b0, "rearm");
    endtask

    task automatic test_reset_mid();
        trig_mask = 32'd0;
        do_arm(3'd4);
        for (int i = 0; i < 5; i++) step_rec(32'h00B00593 + (i << 20), 1'b1);
        n_chk++;
        if (state_o !== 2'd3 || tif.out_valid !== 1'b1)
            $display("FAIL rst pending: state %0d valid %b expected 3 1", state_o, tif.out_valid);
        else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        m_state = 0;
        exp_q.delete();
        n_chk++;
        if (state_o !== 2'd0 || tif.out_valid !== 1'b0 || tif.out_rec !== 106'd0 || triggered !== 1'b0 || overflow !== 1'b0)
            $display("FAIL rst mid: state %0d valid %b rec %h trig %b ovf %b expected all 0", state_o, tif.out_valid, tif.out_rec, triggered, overflow);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_chk++;
        if (state_o !== 2'd0 || tif.out_valid !== 1'b0)
            $display("FAIL rst release: state %0d valid %b expected 0 0", state_o, tif.out_valid);
        else n_pass++;
    endtask

    initial begin
        tif.in_valid    = 1'b0;
        tif.in_instr    = 32'd0;
        tif.in_rd       = 5'd0;
        tif.in_rs1      = 5'd0;
        tif.in_imm      = 32'd0;
        tif.in_rd_value = 32'd0;
        tif.out_ready   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_overflow();
        test_bubbles();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/trace_capture_ctrl.md
# trace_capture_ctrl

Trigger-driven capture controller for the retired-instruction trace of the 5-stage RISC-V pipeline. It records writeback-stage records into a circular buffer, holding pre-trigger history and a programmable number of post-trigger records. After capture it freezes the buffer and drains it oldest-first over a valid/ready port to the console/UART trace sink. It sits beside the writeback stage and sequences the trace datapath; the pipeline itself is never stalled.

## Interface
- DEPTH, 16, buffer entries; power of two, at least 4
- PTR_W, $clog2(DEPTH), pointer width (derived)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  writeback record valid this cycle
- in_instr  in  32  retired instruction word
- in_rd  in  5  destination register index
- in_rs1  in  5  source register 1 index
- in_imm  in  32  signed immediate
- in_rd_value  in  32  signed value written to rd
- arm  in  1  one-cycle pulse: start capture
- abort  in  1  one-cycle pulse: discard and return to IDLE
- trig_instr  in  32  trigger match value
- trig_mask  in  32  1 = compare bit; 0 = any record triggers
- post_count  in  PTR_W  records to capture after the trigger record
- out_valid  out  1  drain record available
- out_ready  in  1  sink accepts record
- out_rec  out  106  {instr, rd, rs1, imm, rd_value}, MSB first
- state_o  out  2  current state
- triggered  out  1  trigger seen in this capture
- overflow  out  1  history was overwritten in this capture

## Operation
- States: IDLE(0), ARMED(1), POST(2), DONE(3).
- Qualified record: in_valid && in_instr != 0. Pipeline bubbles are never stored and never trigger.
- IDLE: nothing is stored. On arm, clear wr_ptr, rd_ptr, count, triggered and overflow, latch post_count into post_rem, and go to ARMED.
- ARMED: every qualified record is written at wr_ptr. When count == DEPTH, the oldest record is overwritten: rd_ptr advances and overflow is set. A match is ((in_instr ^ trig_instr) & trig_mask) == 0 on a qualified record.
  - On a match, the trigger record is stored and triggered is set.
  - If post_rem == 0, go to DONE; otherwise go to POST.
- POST: qualified records are stored with the same overwrite rule. post_rem decrements on each store; the store that brings it to 0 moves the block to DONE.
- DONE: the capture buffer is frozen and inputs are ignored.
  - out_valid = (count != 0). out_rec = mem[rd_ptr] (first-word fall-through).
  - On out_valid && out_ready: rd_ptr advances and count decrements.
  - When the last record transfers, go to IDLE. If DONE is entered with count == 0, IDLE follows on the next cycle.
- abort in any state: go to IDLE and clear count, so out_valid drops. It takes priority over arm and over a simultaneous capture.
- arm outside IDLE is ignored.
- Pointers wrap modulo DEPTH. count ranges over 0..DEPTH and is PTR_W+1 bits wide.

## Timing
- Reset values: state IDLE; out_valid 0; out_rec 0 (mem contents are don't-care but read as 0 after reset); triggered 0; overflow 0; all pointers, count and post_rem 0.
- Capture: a record present at edge N is visible in mem after edge N. A trigger at edge N gives state_o = POST or DONE after edge N.
- Drain: out_rec is valid in the same cycle as out_valid. One record transfers per cycle while out_ready is held.
- Arm at edge N: the block is ARMED after edge N. A qualified record at edge N+1 is the first one stored.
- Reset asserted mid-capture or mid-drain forces reset values immediately; no partial record is output.

## Structure
- The shared package trace_pkg holds:
  - REC_W = 106 and the record field offsets, also used by the trace logger;
  - the state enum;
  - a pack function that builds the record.
- Sub-module trace_ring_buf: DEPTH x REC_W storage with wr_ptr, rd_ptr, count, overwrite-on-full and a fall-through read.
- The controller FSM, trigger compare and post_rem counter live in trace_capture_ctrl.

## Test plan
- DEPTH=8, trig_mask=0, post_count=3, arm, then records with instr 0x00100093, 0x00200113, 0x00300193, 0x00400213 -> DONE after the 4th; drain returns them in order; triggered=1, overflow=0.
- trig_instr=0x00A00513, mask=0xFFFFFFFF, post_count=2, 12 distinct records with the match at index 9 -> drain yields indices 4..11 (8 records), overflow=1.
- Bubble interleave: records 0x00000000 are interleaved with real records -> no zero record is stored, and a zero record never triggers even when trig_instr=0 with full mask.
- Drain backpressure: toggle out_ready 1,0,0,1 -> out_rec holds stable while out_ready=0; exactly count records transfer; IDLE the cycle after the last transfer.
- abort during POST, and abort with arm in the same cycle -> IDLE, out_valid=0, no ARMED entry; a later arm starts a clean capture.
- rst_n low during DONE with 5 records pending -> outputs at reset values within the same cycle; after release, state_o=IDLE.
